// File: rtl/otter_cache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package otter_cache_pkg;

  typedef enum logic {IDLE, FILL} icache_state_t;

  localparam int LINES_DEF = 16;
  localparam int WORDS_DEF = 8;

  localparam int OFF_W = $clog2(WORDS_DEF);
  localparam int IDX_W = $clog2(LINES_DEF);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  function automatic int tag_bits(input int lines, input int words);
    return 30 - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag and data storage: one asynchronous read port, one clocked write port.
// Nothing here is reset; line validity lives in the controller.
module icache_array
  import otter_cache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic                                   clk,
  input  logic [$clog2(LINES)-1:0]               rd_idx,
  input  logic [$clog2(WORDS)-1:0]               rd_off,
  output logic [31:0]                            rd_data,
  output logic [tag_bits(LINES, WORDS)-1:0]      rd_tag,
  input  logic                                   we,
  input  logic [$clog2(LINES)-1:0]               wr_idx,
  input  logic [$clog2(WORDS)-1:0]               wr_off,
  input  logic [31:0]                            wr_data,
  input  logic                                   tag_we,
  input  logic [tag_bits(LINES, WORDS)-1:0]      wr_tag
);

  logic [31:0]                       data_mem [LINES][WORDS];
  logic [tag_bits(LINES, WORDS)-1:0] tag_mem  [LINES];

  always_ff @(posedge clk) begin
    if (we)     data_mem[wr_idx][wr_off] <= wr_data;
    if (tag_we) tag_mem[wr_idx]          <= wr_tag;
  end

  assign rd_data = data_mem[rd_idx][rd_off];
  assign rd_tag  = tag_mem[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only I-cache controller: combinational hit path, in-order
// line burst fill on a miss, memValid1 low for every stall cycle.
module icache_ctrl
  import otter_cache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        memValid1,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_data,
  input  logic        mem_ready
);

  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = tag_bits(LINES, WORDS);

  icache_state_t      state;
  logic [LINES-1:0]   valid;
  logic [TB+IB-1:0]   miss_line;
  logic [OB-1:0]      fill_cnt;

  logic [TB-1:0]      pc_tag;
  logic [IB-1:0]      pc_idx;
  logic [OB-1:0]      pc_off;
  logic [IB-1:0]      miss_idx;
  logic [TB-1:0]      miss_tag;
  logic [TB-1:0]      rd_tag;
  logic [31:0]        rd_data;
  logic               lookup_hit;
  logic               last_word;
  logic               fill_we;
  logic               unused_pc_bits;

  assign pc_tag   = pc[31:IB+OB+2];
  assign pc_idx   = pc[IB+OB+1:OB+2];
  assign pc_off   = pc[OB+1:2];
  assign miss_idx = miss_line[IB-1:0];
  assign miss_tag = miss_line[TB+IB-1:IB];
  assign unused_pc_bits = ^pc[1:0];

  assign lookup_hit = valid[pc_idx] && (rd_tag == pc_tag);
  assign last_word  = (fill_cnt == OB'(WORDS - 1));
  // Reset wins over a write landing on the same edge.
  assign fill_we    = (state == FILL) && mem_ready && !RST;

  icache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
    .clk     (CLK),
    .rd_idx  (pc_idx),
    .rd_off  (pc_off),
    .rd_data (rd_data),
    .rd_tag  (rd_tag),
    .we      (fill_we),
    .wr_idx  (miss_idx),
    .wr_off  (fill_cnt),
    .wr_data (mem_data),
    .tag_we  (fill_we && last_word),
    .wr_tag  (miss_tag)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      valid     <= '0;
      fill_cnt  <= '0;
      miss_line <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!lookup_hit) begin
            miss_line <= {pc_tag, pc_idx};
            fill_cnt  <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (mem_ready) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (last_word) begin
              valid[miss_idx] <= 1'b1;
              state           <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign memValid1 = (state == IDLE) && lookup_hit;
  assign instr     = rd_data;
  assign mem_rd    = (state == FILL);
  assign mem_addr  = (state == FILL) ? {miss_line, fill_cnt, 2'b00} : 32'h0;

endmodule
